reg_op_sequencer: RTL and testbench

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

---
 rtl/reg_op_sequencer_pkg.sv | 44 ++++
 rtl/reg_op_sequencer_if.sv | 34 +++
 rtl/reg_op_sequencer_register.sv | 41 ++++
 rtl/reg_op_sequencer.sv | 144 ++++++++++++++
 tb/tb_reg_op_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/reg_op_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reg_op_sequencer_pkg
// Shared definitions for the register-operation sequencer and its bench:
//   DATA_W      width of the controlled register
//   op_e        command op-codes carried on cmd_op
//   state_e     sequencer FSM state encodings
//   reg_ctrl_t  one-hot control bundle driven into the register datapath
// ---------------------------------------------------------------------------
package reg_op_sequencer_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [2:0] {
        OP_CLR  = 3'd0,
        OP_LOAD = 3'd1,
        OP_INC  = 3'd2,
        OP_DEC  = 3'd3,
        OP_SHR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_ROR  = 3'd6,
        OP_ROL  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic cl;
        logic ld;
        logic inc;
        logic dec;
        logic sr;
        logic sl;
    } reg_ctrl_t;

    // Ops that honour the repeat count; CLR/LOAD always take a single step.
    function automatic logic op_is_repeated(input op_e op);
        return (op != OP_CLR) && (op != OP_LOAD);
    endfunction

endpackage

// File: rtl/reg_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// reg_op_sequencer_if
// Command/response bundle between a command source and the sequencer.
//   cmd_valid/cmd_ready  command handshake; cmd_op, cmd_data, cmd_cnt payload
//   rsp_valid/rsp_ready  response handshake; rsp_data, rsp_flag payload
//   busy                 sequencer is not idle
// master: command source / response sink.  slave: the sequencer.
// ---------------------------------------------------------------------------
interface reg_op_sequencer_if #(
    parameter int CNT_W = 4
);
    import reg_op_sequencer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [CNT_W-1:0]  cmd_cnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_flag;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_cnt, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_flag, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_cnt, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_flag, busy
    );
endinterface

// File: rtl/reg_op_sequencer_register.sv
// ---------------------------------------------------------------------------
// reg_op_sequencer_register
// DATA_W-bit register with clear, parallel load, increment, decrement and
// single-bit shift right/left with external serial fill.
//   clk, rst_n  clock and asynchronous active-low reset (register -> 0)
//   ctrl        at most one control active per cycle
//   in          parallel load value
//   ir / il     bit shifted into the MSB (sr) / LSB (sl)
//   q           current register value
// ---------------------------------------------------------------------------
module reg_op_sequencer_register
    import reg_op_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  reg_ctrl_t         ctrl,
    input  logic [DATA_W-1:0] in,
    input  logic              ir,
    input  logic              il,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] value_q;
    logic [DATA_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (ctrl.cl)       value_d = '0;
        else if (ctrl.ld)  value_d = in;
        else if (ctrl.inc) value_d = value_q + 1'b1;
        else if (ctrl.dec) value_d = value_q - 1'b1;
        else if (ctrl.sr)  value_d = {ir, value_q[DATA_W-1:1]};
        else if (ctrl.sl)  value_d = {value_q[DATA_W-2:0], il};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end

    assign q = value_q;
endmodule

// File: rtl/reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// reg_op_sequencer
// Accepts one command at a time, steps the register datapath once per EXEC
// cycle for the requested count, then holds the result until it is taken.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         slave side of reg_op_sequencer_if (command in, response out)
// rsp_flag records any carry/borrow or a 1 shifted out during the command.
// ---------------------------------------------------------------------------
module reg_op_sequencer
    import reg_op_sequencer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_op_sequencer_if.slave   bus
);
    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flag_q, flag_d;

    reg_ctrl_t         reg_ctrl;
    logic              reg_ir;
    logic              reg_il;
    logic [DATA_W-1:0] reg_value;
    logic              step_carry;
    logic              cmd_ready;

    // Gated by rst_n so the port reads low throughout reset and rises as
    // soon as reset is released.
    assign cmd_ready = rst_n && (state_q == ST_IDLE);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        flag_d     = flag_q;
        reg_ctrl   = '0;
        reg_ir     = 1'b0;
        reg_il     = 1'b0;
        step_carry = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    op_d   = op_e'(bus.cmd_op);
                    data_d = bus.cmd_data;
                    flag_d = 1'b0;
                    if (!op_is_repeated(op_e'(bus.cmd_op))) begin
                        // Single step: reuse the counter so EXEC exits uniformly.
                        cnt_d   = CNT_W'(1);
                        state_d = ST_EXEC;
                    end else if (bus.cmd_cnt == '0) begin
                        cnt_d   = '0;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = bus.cmd_cnt;
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                unique case (op_q)
                    OP_CLR:  reg_ctrl.cl = 1'b1;
                    OP_LOAD: reg_ctrl.ld = 1'b1;
                    OP_INC: begin
                        reg_ctrl.inc = 1'b1;
                        step_carry   = (reg_value == '1);
                    end
                    OP_DEC: begin
                        reg_ctrl.dec = 1'b1;
                        step_carry   = (reg_value == '0);
                    end
                    OP_SHR: begin
                        reg_ctrl.sr = 1'b1;
                        reg_ir      = data_q[0];
                        step_carry  = reg_value[0];
                    end
                    OP_SHL: begin
                        reg_ctrl.sl = 1'b1;
                        reg_il      = data_q[0];
                        step_carry  = reg_value[DATA_W-1];
                    end
                    OP_ROR: begin
                        reg_ctrl.sr = 1'b1;
                        reg_ir      = reg_value[0];
                        step_carry  = reg_value[0];
                    end
                    OP_ROL: begin
                        reg_ctrl.sl = 1'b1;
                        reg_il      = reg_value[DATA_W-1];
                        step_carry  = reg_value[DATA_W-1];
                    end
                    default: ;
                endcase
                flag_d = flag_q | step_carry;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end

            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_CLR;
            data_q  <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    reg_op_sequencer_register u_register (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (reg_ctrl),
        .in    (data_q),
        .ir    (reg_ir),
        .il    (reg_il),
        .q     (reg_value)
    );

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = reg_value;
    assign bus.rsp_flag  = flag_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_op_sequencer
// Directed bench for reg_op_sequencer: issues commands through the interface
// and compares latency, result data, flag and handshake behaviour against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_reg_op_sequencer;
    import reg_op_sequencer_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   inc_pulses;
    int   dec_pulses;

    reg_op_sequencer_if #(.CNT_W(4)) bus ();

    reg_op_sequencer #(.CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count register step pulses in the middle of each cycle.
    initial begin
        inc_pulses = 0;
        dec_pulses = 0;
    end
    always @(negedge clk) begin
        if (rst_n && dut.reg_ctrl.inc) inc_pulses = inc_pulses + 1;
        if (rst_n && dut.reg_ctrl.dec) dec_pulses = dec_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    // Offer a command at a negedge; returns 1ns after the accepting edge.
    task automatic issue(input string tag, input op_e op, input logic [3:0] data,
                         input logic [3:0] cnt);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_cnt   = cnt;
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Count edges after acceptance until rsp_valid; bounded.
    task automatic wait_rsp(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic ack;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("ack_rsp_valid_low", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic run(input string tag, input op_e op, input logic [3:0] data,
                       input logic [3:0] cnt, input int exp_lat,
                       input logic [3:0] exp_data, input logic exp_flag);
        issue(tag, op, data, cnt);
        wait_rsp(tag, exp_lat);
        check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_data));
        check({tag, "_flag"}, 32'(bus.rsp_flag), 32'(exp_flag));
        ack();
    endtask

    initial begin
        int  start;
        logic seen;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_CLR;
        bus.cmd_data  = 4'h0;
        bus.cmd_cnt   = 4'h0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_rsp_flag",  32'(bus.rsp_flag),  32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        rst_n = 1'b1;

        // LOAD A: response one edge after acceptance
        run("load_a", OP_LOAD, 4'hA, 4'h0, 1, 4'hA, 1'b0);

        // LOAD E then INC x3: F, 0 (wrap), 1
        run("load_e", OP_LOAD, 4'hE, 4'h0, 1, 4'hE, 1'b0);
        start = inc_pulses;
        run("inc3", OP_INC, 4'h0, 4'd3, 3, 4'h1, 1'b1);
        check("inc3_pulses", 32'(inc_pulses - start), 32'd3);

        // LOAD 9, ROR 1 -> C (1 out); ROL 4 -> C (1,1 out first)
        run("load_9", OP_LOAD, 4'h9, 4'h0, 1, 4'h9, 1'b0);
        run("ror1", OP_ROR, 4'h0, 4'd1, 1, 4'hC, 1'b1);
        run("rol4", OP_ROL, 4'h0, 4'd4, 4, 4'hC, 1'b1);

        // LOAD 5, SHL fill 1 x2: 0101->1011->0111; second step shifts out a 1
        run("load_5", OP_LOAD, 4'h5, 4'h0, 1, 4'h5, 1'b0);
        run("shl2", OP_SHL, 4'h1, 4'd2, 2, 4'h7, 1'b1);
        // DEC cnt=0: immediate response, no step, flag cleared on acceptance
        start = dec_pulses;
        run("dec0", OP_DEC, 4'h0, 4'd0, 0, 4'h7, 1'b0);
        check("dec0_pulses", 32'(dec_pulses - start), 32'd0);

        // CLR, then DEC x2 from 0: F (borrow), E
        run("clr", OP_CLR, 4'h0, 4'd9, 1, 4'h0, 1'b0);
        run("dec2", OP_DEC, 4'h0, 4'd2, 2, 4'hE, 1'b1);

        // Response held for 5 cycles with a competing command offered
        run("load_3", OP_LOAD, 4'h3, 4'h0, 1, 4'h3, 1'b0);
        issue("shr1", OP_SHR, 4'h0, 4'd1);
        wait_rsp("shr1", 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.cmd_valid = (i >= 1);
            bus.cmd_op    = OP_LOAD;
            bus.cmd_data  = 4'h0;
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rsp_data",  32'(bus.rsp_data),  32'h1);
            check("hold_rsp_flag",  32'(bus.rsp_flag),  32'd1);
            check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        ack();
        repeat (2) @(negedge clk);
        check("hold_after_busy", 32'(bus.busy),     32'd0);
        check("hold_after_data", 32'(bus.rsp_data), 32'h1);

        // Reset in the middle of INC x8
        issue("inc8", OP_INC, 4'h0, 4'd8);
        repeat (3) @(negedge clk);
        check("inc8_busy_before_rst", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("mid_rst_busy",      32'(bus.busy),      32'd0);
        check("mid_rst_register",  32'(dut.reg_value), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("post_rst_no_rsp", 32'(seen), 32'd0);
        check("post_rst_register", 32'(bus.rsp_data), 32'd0);

        // Normal operation resumes
        run("load_2", OP_LOAD, 4'h2, 4'h0, 1, 4'h2, 1'b0);
        run("inc1", OP_INC, 4'h0, 4'd1, 1, 4'h3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
